// File: rtl/async_receiver.sv
// 8N1 serial receiver: synchronises RxD, oversamples each bit 16x, decides each
// bit by majority vote of three mid-bit samples, and strobes out framed bytes.
module async_receiver #(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 16
) (
    input  logic       CLK50MHZ,
    input  logic       RST_N,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_framing_error,
    output logic       RxD_busy
);

    localparam int DIV = (ClkFrequency + Baud * 8) / (Baud * 16);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(Oversampling);

    localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
    localparam logic [TW-1:0] SAMPLE_A    = TW'(Oversampling / 2 - 1);
    localparam logic [TW-1:0] SAMPLE_B    = TW'(Oversampling / 2);
    localparam logic [TW-1:0] SAMPLE_LAST = TW'(Oversampling / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    samp_q, samp_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          ferr_q, ferr_d;

    logic          tick;
    logic          decide;
    logic          majority;

    // Two-flop synchroniser; idle-high so reset never looks like a start bit.
    always_comb begin
        rx_meta_d = RxD;
        rx_s_d    = rx_meta_q;
    end

    // Oversampling timebase: held at zero outside active bit reception so the
    // first tick lands a fixed distance after the detected falling edge.
    always_comb begin
        tick   = (state_q != S_IDLE) && (state_q != S_WAIT_HIGH) && (presc_q == PRESC_LAST);
        decide = tick && (tcnt_q == SAMPLE_LAST);

        presc_d = presc_q;
        tcnt_d  = tcnt_q;
        samp_d  = samp_q;

        if (state_q == S_IDLE || state_q == S_WAIT_HIGH) begin
            presc_d = '0;
            tcnt_d  = '0;
        end else if (tick) begin
            presc_d = '0;
            tcnt_d  = tcnt_q + TW'(1);
            if (tcnt_q == SAMPLE_A) samp_d[0] = rx_s_q;
            if (tcnt_q == SAMPLE_B) samp_d[1] = rx_s_q;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        // Third vote is the live sample taken on the deciding tick itself.
        majority = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (decide) begin
                    if (majority) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d   = {majority, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a following start edge.
                if (decide) begin
                    if (majority) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before this edge.
    always_ff @(posedge CLK50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            presc_q   <= '0;
            tcnt_q    <= '0;
            samp_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            presc_q   <= presc_d;
            tcnt_q    <= tcnt_d;
            samp_q    <= samp_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
        end
    end

    assign RxD_data          = data_q;
    assign RxD_data_ready    = ready_q;
    assign RxD_framing_error = ferr_q;
    assign RxD_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_async_receiver.sv
// Self-checking bench for async_receiver: drives 8N1 frames on RxD and checks
// received bytes, error strobes and busy against a frame-level scoreboard.
module tb_async_receiver;

    localparam int CLK_F = 1600000;
    localparam int BAUD  = 10000;
    localparam int BIT   = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ferr;
    logic       rx_busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_data = 8'h00;
    int         err_cnt = 0;
    int         proto_viol = 0;
    int         busy_viol = 0;
    logic       prev_pulse = 1'b0;
    logic       prev_busy = 1'b0;

    async_receiver #(
        .ClkFrequency(CLK_F),
        .Baud(BAUD),
        .Oversampling(16)
    ) dut (
        .CLK50MHZ(clk),
        .RST_N(rst_n),
        .RxD(rxd),
        .RxD_data(rx_data),
        .RxD_data_ready(rx_ready),
        .RxD_framing_error(rx_ferr),
        .RxD_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // Monitor samples outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pulse = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (rx_ready === 1'b1) begin
                got_q.push_back(rx_data);
                if (rx_busy !== 1'b0 || prev_busy !== 1'b1) busy_viol++;
            end
            if (rx_ferr === 1'b1) err_cnt++;
            if ((rx_ready && rx_ferr) || ((rx_ready || rx_ferr) && prev_pulse)) proto_viol++;
            prev_pulse = rx_ready | rx_ferr;
            prev_busy  = rx_busy;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first and stop; optionally inverts bit
    // spike_bit for 20 cycles around its centre.
    task automatic send_frame(input logic [7:0] b, input int period,
                              input logic stop_v, input int spike_bit);
        logic v;
        for (int i = -1; i <= 8; i++) begin
            v = (i < 0) ? 1'b0 : (i == 8) ? stop_v : b[i];
            for (int c = 0; c < period; c++) begin
                @(negedge clk);
                rxd = (i == spike_bit && c >= 70 && c < 90) ? ~v : v;
            end
        end
    endtask

    // Scoreboard: a well-framed byte is expected out unchanged.
    task automatic send_good(input logic [7:0] b, input int period, input int spike_bit);
        send_frame(b, period, 1'b1, spike_bit);
        exp_q.push_back(b);
        exp_data = b;
    endtask

    task automatic start_test();
        exp_q.delete();
        got_q.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rxd   = 1'b1;
        hold(5);
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", rx_ready); end
        tests++; if (rx_ferr !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", rx_ferr); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        rst_n = 1'b1;
        hold(20);
    endtask

    task automatic test_single();
        start_test();
        send_good(8'hA5, BIT, -1);
        hold(100);
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL a5_pulses: got %0d expected 1", got_q.size()); end
        tests++; if (got_q.size() > 0 && got_q[0] !== 8'hA5) begin fails++; $display("FAIL a5_strobe_data: got %h expected a5", got_q[0]); end
        tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL a5_held_data: got %h expected a5", rx_data); end
        tests++; if (err_cnt != 0) begin fails++; $display("FAIL a5_ferr: got %0d expected 0", err_cnt); end
        tests++; if (busy_viol != 0) begin fails++; $display("FAIL a5_busy_fall: got %0d bad pulses expected 0", busy_viol); end
    endtask

    task automatic test_back_to_back();
        start_test();
        send_good(8'h00, BIT, -1);
        send_good(8'hFF, BIT, -1);
        send_good(8'h55, BIT, -1);
        hold(200);
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_glitch();
        logic saw_busy;
        start_test();
        saw_busy = 1'b0;
        rxd = 1'b0;
        for (int c = 0; c < 30; c++) begin @(negedge clk); if (rx_busy) saw_busy = 1'b1; end
        rxd = 1'b1;
        for (int c = 0; c < 150; c++) begin @(negedge clk); if (rx_busy) saw_busy = 1'b1; end
        tests++; if (saw_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_seen: got %b expected 1", saw_busy); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_back_idle: got %b expected 0", rx_busy); end
        tests++; if (got_q.size() != 0 || err_cnt != 0) begin fails++; $display("FAIL glitch_pulses: got %0d ready %0d err expected 0 0", got_q.size(), err_cnt); end
        tests++; if (rx_data !== exp_data) begin fails++; $display("FAIL glitch_data: got %h expected %h", rx_data, exp_data); end
    endtask

    task automatic test_framing();
        start_test();
        send_frame(8'h3C, BIT, 1'b0, -1);
        hold(3 * BIT);
        tests++; if (err_cnt != 1) begin fails++; $display("FAIL ferr_count: got %0d expected 1", err_cnt); end
        tests++; if (got_q.size() != 0) begin fails++; $display("FAIL ferr_no_ready: got %0d expected 0", got_q.size()); end
        tests++; if (rx_data !== exp_data) begin fails++; $display("FAIL ferr_data_kept: got %h expected %h", rx_data, exp_data); end
        tests++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL ferr_busy_low_line: got %b expected 1", rx_busy); end
        rxd = 1'b1;
        hold(10);
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL ferr_busy_released: got %b expected 0", rx_busy); end
        send_good(8'h81, BIT, -1);
        hold(100);
        tests++; if (got_q.size() != 1 || rx_data !== 8'h81) begin fails++; $display("FAIL ferr_recover: got %0d pulses data %h expected 1 81", got_q.size(), rx_data); end
    endtask

    task automatic test_spike();
        start_test();
        send_good(8'h0F, BIT, 3);
        hold(100);
        tests++; if (got_q.size() != 1 || err_cnt != 0) begin fails++; $display("FAIL spike_pulses: got %0d ready %0d err expected 1 0", got_q.size(), err_cnt); end
        tests++; if (rx_data !== 8'h0F) begin fails++; $display("FAIL spike_data: got %h expected 0f", rx_data); end
    endtask

    task automatic test_reset_mid_frame();
        start_test();
        fork
            send_frame(8'hF0, BIT, 1'b1, -1);
            begin
                hold(850);
                rst_n = 1'b0;
                hold(3);
                tests++; if (rx_data !== 8'h00 || rx_ready !== 1'b0 || rx_ferr !== 1'b0 || rx_busy !== 1'b0) begin
                    fails++; $display("FAIL midreset_outputs: got data %h rdy %b ferr %b busy %b expected 00 0 0 0", rx_data, rx_ready, rx_ferr, rx_busy);
                end
                hold(147);
                rst_n = 1'b1;
            end
        join
        exp_data = 8'h00;
        hold(200);
        tests++; if (got_q.size() != 0 || err_cnt != 0) begin fails++; $display("FAIL midreset_no_pulse: got %0d ready %0d err expected 0 0", got_q.size(), err_cnt); end
        tests++; if (rx_data !== exp_data) begin fails++; $display("FAIL midreset_data: got %h expected %h", rx_data, exp_data); end
        send_good(8'h5A, BIT, -1);
        hold(100);
        tests++; if (got_q.size() != 1 || rx_data !== 8'h5A) begin fails++; $display("FAIL midreset_next: got %0d pulses data %h expected 1 5a", got_q.size(), rx_data); end
    endtask

    // Random bytes, random idle gaps and sender bit periods within +-2.5%.
    task automatic test_random();
        start_test();
        for (int n = 0; n < 16; n++) begin
            send_good(8'($urandom_range(255, 0)), int'($urandom_range(164, 156)), -1);
            hold(int'($urandom_range(120, 0)));
        end
        hold(200);
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (err_cnt != 0) begin fails++; $display("FAIL rand_ferr: got %0d expected 0", err_cnt); end
        tests++; if (rx_data !== exp_data) begin fails++; $display("FAIL rand_last_data: got %h expected %h", rx_data, exp_data); end
    endtask

    task automatic test_protocol();
        tests++; if (proto_viol != 0) begin fails++; $display("FAIL strobe_exclusive: got %0d violations expected 0", proto_viol); end
        tests++; if (busy_viol != 0) begin fails++; $display("FAIL busy_at_strobe: got %0d violations expected 0", busy_viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_spike();
        test_reset_mid_frame();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
